// File: rtl/vblank_update_scheduler_pkg.sv
// Shared defaults and FSM encoding for the vertical-blanking update scheduler.
package vblank_update_scheduler_pkg;

  localparam int H_VIDEO_DEF     = 640;
  localparam int V_VIDEO_DEF     = 480;
  localparam int N_CLIENTS_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GRANT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/vblank_update_scheduler_prio_pick.sv
// Combinational lowest-set-bit picker: one-hot of the winning request plus its binary index.
module prio_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Walk from the top so the lowest set bit is the last (winning) assignment.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants game-state update clients one at a time, in fixed priority, only during vertical blanking,
// with per-client timeout and overrun detection so renderers never see mid-frame state changes.
module vblank_update_scheduler
  import vblank_update_scheduler_pkg::*;
#(
  parameter int H_VIDEO     = H_VIDEO_DEF,
  parameter int V_VIDEO     = V_VIDEO_DEF,
  parameter int N_CLIENTS   = N_CLIENTS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic [N_CLIENTS-1:0] client_req,
  input  logic [N_CLIENTS-1:0] client_done,
  output logic [N_CLIENTS-1:0] client_grant,
  output logic                 frame_tick,
  output logic                 sched_busy,
  output logic                 timeout_err,
  output logic                 overrun_err,
  output logic [15:0]          frame_count
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  if (H_VIDEO < 1 || H_VIDEO > 1024) begin : g_bad_h
    $error("H_VIDEO must fit the 10-bit pixel_x range");
  end
  if (V_VIDEO < 1 || V_VIDEO > 1023) begin : g_bad_v
    $error("V_VIDEO must fit the 10-bit pixel_y range and be nonzero");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_t
    $error("TIMEOUT_CYC must be at least 2");
  end

  sched_state_e         state, state_next;
  logic [N_CLIENTS-1:0] pending, pending_next;
  logic [N_CLIENTS-1:0] remaining;
  logic [N_CLIENTS-1:0] cur_onehot;
  logic [IW-1:0]        cur_idx, cur_idx_next;
  logic [TW-1:0]        timer, timer_next;
  logic                 set_timeout, set_overrun;
  logic                 done_hit, timer_hit;

  logic [N_CLIENTS-1:0] pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;

  logic vblank_start, vblank_end;

  assign vblank_start = (pixel_y == 10'(V_VIDEO)) && (pixel_x == 10'd0);
  assign vblank_end   = (pixel_y == 10'd0) && (pixel_x == 10'd0);

  prio_pick #(
    .N  (N_CLIENTS),
    .IW (IW)
  ) u_pick (
    .req    (pending),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign cur_onehot = N_CLIENTS'(1) << cur_idx;
  assign done_hit   = |(client_done & cur_onehot);
  assign timer_hit  = (timer == TW'(TIMEOUT_CYC - 1));

  // Blanking boundaries take precedence over handshake events; done beats a simultaneous timeout.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    cur_idx_next = cur_idx;
    timer_next   = timer;
    set_timeout  = 1'b0;
    set_overrun  = 1'b0;
    remaining    = pending & ~(done_hit ? cur_onehot : '0);
    client_grant = '0;
    sched_busy   = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (vblank_start) begin
          state_next   = ST_SCAN;
          pending_next = client_req;
        end
      end
      ST_SCAN: begin
        if (vblank_start) begin
          set_overrun  = 1'b1;
          pending_next = client_req;
        end else if (vblank_end) begin
          state_next   = ST_IDLE;
          pending_next = '0;
          set_overrun  = |pending;
        end else if (pick_valid) begin
          state_next   = ST_GRANT;
          cur_idx_next = pick_idx;
          timer_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_GRANT: begin
        client_grant = cur_onehot;
        if (vblank_start) begin
          set_overrun  = 1'b1;
          state_next   = ST_SCAN;
          pending_next = client_req;
        end else if (vblank_end) begin
          state_next   = ST_IDLE;
          pending_next = '0;
          set_overrun  = !done_hit || (|remaining);
        end else if (done_hit) begin
          state_next   = ST_SCAN;
          pending_next = remaining;
        end else if (timer_hit) begin
          state_next   = ST_SCAN;
          pending_next = pending & ~cur_onehot;
          set_timeout  = 1'b1;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: begin
        state_next   = ST_IDLE;
        pending_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      cur_idx <= '0;
      timer   <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      cur_idx <= cur_idx_next;
      timer   <= timer_next;
    end
  end

  // Frame bookkeeping and sticky error flags; errors clear only through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick  <= 1'b0;
      frame_count <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_tick  <= vblank_start;
      frame_count <= frame_count + {15'd0, vblank_start};
      if (set_timeout) timeout_err <= 1'b1;
      if (set_overrun) overrun_err <= 1'b1;
    end
  end

endmodule
